// File: rtl/reg_if.sv
// rtl/reg_if.sv - PWM register interface: CTRL/STATUS/SCRATCH/ID with registered read data
// Single-cycle write/read bus; status_in is mirrored through one register stage.
module reg_if #(
  parameter logic [31:0] CTRL_RST = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE = 32'h5057_4D01
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic [31:0] ctrl,
  input  logic [31:0] status_in,
  output logic [31:0] status
);

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h04;
  localparam logic [7:0] ADDR_SCRATCH = 8'h08;
  localparam logic [7:0] ADDR_ID      = 8'h0C;

  logic [31:0] r_ctrl;
  logic [31:0] r_scratch;
  logic [31:0] r_status;
  logic [31:0] r_rdata;
  logic [31:0] w_rd_mux;

  // Read mux sees pre-edge register values, so a same-cycle write+read returns old data.
  always_comb begin
    w_rd_mux = 32'h0;
    case (addr)
      ADDR_CTRL:    w_rd_mux = r_ctrl;
      ADDR_STATUS:  w_rd_mux = r_status;
      ADDR_SCRATCH: w_rd_mux = r_scratch;
      ADDR_ID:      w_rd_mux = ID_VALUE;
      default:      w_rd_mux = 32'h0;
    endcase
  end

  // reset_n is active-high in this codebase despite its name.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_ctrl    <= CTRL_RST;
      r_scratch <= 32'h0;
      r_status  <= 32'h0;
      r_rdata   <= 32'h0;
    end else begin
      r_status <= status_in;
      if (wen) begin
        case (addr)
          ADDR_CTRL:    r_ctrl    <= wdata;
          ADDR_SCRATCH: r_scratch <= wdata;
          default:      ;
        endcase
      end
      if (ren) begin
        r_rdata <= w_rd_mux;
      end
    end
  end

  assign rdata  = r_rdata;
  assign ctrl   = r_ctrl;
  assign status = r_status;

endmodule

// File: tb/tb_reg_if.sv
// tb/tb_reg_if.sv - table-driven self-checking bench for reg_if
module tb_reg_if;

  logic        clk;
  logic        reset_n;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic [31:0] ctrl;
  logic [31:0] status_in;
  logic [31:0] status;

  int n_checks;
  int n_errors;

  typedef struct {
    logic        wen;
    logic        ren;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] sin;
    logic [31:0] exp_rdata;
    logic [31:0] exp_ctrl;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];

  reg_if dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .addr      (addr),
    .wdata     (wdata),
    .wen       (wen),
    .ren       (ren),
    .rdata     (rdata),
    .ctrl      (ctrl),
    .status_in (status_in),
    .status    (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    //                wen  ren  addr    wdata          status_in      exp_rdata      exp_ctrl
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0000, 32'h1234_5678};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 32'h0000_0000, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678};
    vecs[3]  = '{1'b1, 1'b0, 8'h08, 32'hA5A5_5A5A, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678};
    vecs[4]  = '{1'b0, 1'b1, 8'h08, 32'h0000_0000, 32'hDEAD_BEEF, 32'hA5A5_5A5A, 32'h1234_5678};
    vecs[5]  = '{1'b1, 1'b0, 8'h04, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hA5A5_5A5A, 32'h1234_5678};
    vecs[6]  = '{1'b1, 1'b0, 8'h0C, 32'h0000_0000, 32'hDEAD_BEEF, 32'hA5A5_5A5A, 32'h1234_5678};
    vecs[7]  = '{1'b0, 1'b1, 8'h0C, 32'h0000_0000, 32'hDEAD_BEEF, 32'h5057_4D01, 32'h1234_5678};
    vecs[8]  = '{1'b1, 1'b0, 8'h10, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h5057_4D01, 32'h1234_5678};
    vecs[9]  = '{1'b0, 1'b1, 8'h10, 32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 32'h1234_5678};
    vecs[10] = '{1'b0, 1'b1, 8'h04, 32'h0000_0000, 32'h2222_2222, 32'h1111_1111, 32'h1234_5678};
    vecs[11] = '{1'b0, 1'b1, 8'h08, 32'h0000_0000, 32'h2222_2222, 32'hA5A5_5A5A, 32'h1234_5678};
    vecs[12] = '{1'b0, 1'b1, 8'h00, 32'h0000_0000, 32'h2222_2222, 32'h1234_5678, 32'h1234_5678};
    vecs[13] = '{1'b1, 1'b1, 8'h00, 32'h0000_00FF, 32'h2222_2222, 32'h1234_5678, 32'h0000_00FF};
    vecs[14] = '{1'b0, 1'b1, 8'h00, 32'h0000_0000, 32'h2222_2222, 32'h0000_00FF, 32'h0000_00FF};
    vecs[15] = '{1'b0, 1'b0, 8'h08, 32'h0000_0000, 32'h2222_2222, 32'h0000_00FF, 32'h0000_00FF};
    vecs[16] = '{1'b0, 1'b1, 8'h01, 32'h0000_0000, 32'h2222_2222, 32'h0000_0000, 32'h0000_00FF};

    reset_n   = 1'b1;
    addr      = 8'h00;
    wdata     = 32'h0;
    wen       = 1'b0;
    ren       = 1'b0;
    status_in = 32'hDEAD_BEEF;

    // Held in reset across edges, with a bus access attempted.
    @(negedge clk);
    wen = 1'b1; ren = 1'b1; addr = 8'h00; wdata = 32'hFFFF_0000;
    @(posedge clk); #1;
    check("reset_ctrl", ctrl, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_status", status, 32'h0);
    @(negedge clk);
    wen = 1'b0; ren = 1'b0;
    reset_n = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      wen = vecs[i].wen; ren = vecs[i].ren; addr = vecs[i].addr;
      wdata = vecs[i].wdata; status_in = vecs[i].sin;
      @(posedge clk); #1;
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_ctrl", i), ctrl, vecs[i].exp_ctrl);
      check($sformatf("v%0d_status", i), status, vecs[i].sin);
    end

    // Asynchronous reset between edges returns CTRL immediately.
    @(negedge clk);
    wen = 1'b1; ren = 1'b0; addr = 8'h00; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    check("pre_async_ctrl", ctrl, 32'h1234_5678);
    wen = 1'b0;
    #1 reset_n = 1'b1;
    #1;
    check("async_ctrl", ctrl, 32'h0);
    check("async_rdata", rdata, 32'h0);
    check("async_status", status, 32'h0);

    // Write attempted under reset must not land in SCRATCH.
    @(negedge clk);
    wen = 1'b1; addr = 8'h08; wdata = 32'h7777_7777;
    @(posedge clk); #1;
    check("rst_wr_ctrl", ctrl, 32'h0);
    @(negedge clk);
    wen = 1'b0; reset_n = 1'b0; ren = 1'b1; addr = 8'h08;
    @(posedge clk); #1;
    check("post_rst_scratch", rdata, 32'h0);
    @(negedge clk);
    ren = 1'b1; addr = 8'h0C;
    @(posedge clk); #1;
    check("post_rst_id", rdata, 32'h5057_4D01);
    ren = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
